// File: rtl/fsm_input_cond_if.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_input_cond_if
//  Brief    : Raw-input / conditioned-output bundle between the input
//             conditioner and its surroundings (raw pins in, clean x/y out).
//  Revision : 1.0 - initial release
// ============================================================================
interface fsm_input_cond_if;

  logic x_raw;   // raw asynchronous x input
  logic y_raw;   // raw asynchronous y input
  logic x;       // committed x level
  logic y;       // committed y level
  logic x_rise;  // one-cycle strobe, x 0->1
  logic y_rise;  // one-cycle strobe, y 0->1
  logic upd;     // one-cycle strobe, {x,y} changed

  // Environment side: drives the raw pins, observes the conditioned levels.
  modport master (
    output x_raw, y_raw,
    input  x, y, x_rise, y_rise, upd
  );

  // Conditioner side: samples the raw pins, drives the conditioned levels.
  modport slave (
    input  x_raw, y_raw,
    output x, y, x_rise, y_rise, upd
  );

endinterface
`default_nettype wire

// File: rtl/fsm_input_cond.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_input_cond
//  Brief    : Two-channel synchroniser + debouncer feeding the fsm block.
//             Both channels are committed jointly so that near-simultaneous
//             raw changes reach the FSM as a single combined transition.
//  Revision : 1.0 - initial release
// ============================================================================
module fsm_input_cond #(
  parameter int DB_CYCLES = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  fsm_input_cond_if.slave  bus
);

  // Counter width is derived from DB_CYCLES; at least one bit is kept so the
  // degenerate DB_CYCLES=1 case still has a legal vector.
  localparam int              CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DB_CYCLES - 1);

  // Channel index 1 carries x, index 0 carries y, so {x,y} maps onto [1:0].
  logic [1:0] raw;
  logic [1:0] cand;
  logic [1:0] stable;

  assign raw = {bus.x_raw, bus.y_raw};

  generate
    for (genvar g = 0; g < 2; g++) begin : g_ch
      logic          s1_q;
      logic          s2_q;
      logic          cand_q;
      logic          cand_d;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // Two-flop synchroniser followed by the candidate/count registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_q   <= 1'b0;
          s2_q   <= 1'b0;
          cand_q <= 1'b0;
          cnt_q  <= '0;
        end else begin
          s1_q   <= raw[g];
          s2_q   <= s1_q;
          cand_q <= cand_d;
          cnt_q  <= cnt_d;
        end
      end

      // Any mismatch restarts the count; a matching level counts up and
      // saturates at CNT_MAX so a long-stable channel stays stable.
      always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (s2_q != cand_q) begin
          cand_d = s2_q;
          cnt_d  = '0;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d  = cnt_q + 1'b1;
        end
      end

      assign cand[g]   = cand_q;
      assign stable[g] = (s2_q == cand_q) && (cnt_q == CNT_MAX);
    end
  endgenerate

  logic [1:0] out_q;
  logic [1:0] out_d;
  logic [1:0] rise_q;
  logic [1:0] rise_d;
  logic       upd_q;
  logic       upd_d;
  logic       commit;

  // A commit needs both channels settled; a chattering channel deliberately
  // holds back the other one so the FSM never sees a split transition.
  assign commit = (&stable) && (cand != out_q);

  // Next committed levels and the single-cycle strobes.
  always_comb begin
    out_d  = out_q;
    rise_d = 2'b00;
    upd_d  = 1'b0;
    if (commit) begin
      out_d  = cand;
      rise_d = cand & ~out_q;
      upd_d  = 1'b1;
    end
  end

  // Output registers; every output is flop-driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= 2'b00;
      rise_q <= 2'b00;
      upd_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      rise_q <= rise_d;
      upd_q  <= upd_d;
    end
  end

  assign bus.x      = out_q[1];
  assign bus.y      = out_q[0];
  assign bus.x_rise = rise_q[1];
  assign bus.y_rise = rise_q[0];
  assign bus.upd    = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_input_cond.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsm_input_cond
//  Brief    : Directed, table-driven bench for fsm_input_cond (DB_CYCLES=4).
//             Each vector drives {rst,x_raw,y_raw} for one clock and checks
//             {x,y,x_rise,y_rise,upd} just after that edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_input_cond;

  logic clk;
  logic rst;

  fsm_input_cond_if bus ();

  fsm_input_cond #(.DB_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       xr;
    logic       yr;
    logic [4:0] e;    // {x, y, x_rise, y_rise, upd}
    string      nm;
  } vec_t;

  vec_t tbl[$];
  int   n_vec;
  int   n_bad;

  function automatic void add(input int n, input logic r, input logic xr,
                              input logic yr, input logic [4:0] e,
                              input string nm);
    vec_t v;
    v.r  = r;
    v.xr = xr;
    v.yr = yr;
    v.e  = e;
    v.nm = nm;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  task automatic step(input logic r, input logic xr, input logic yr,
                      input logic [4:0] e, input string nm);
    logic [4:0] got;
    rst       = r;
    bus.x_raw = xr;
    bus.y_raw = yr;
    @(posedge clk);
    #1;
    got = {bus.x, bus.y, bus.x_rise, bus.y_rise, bus.upd};
    n_vec++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s vec %0d: got {x,y,xr,yr,upd}=%b expected %b",
               nm, n_vec, got, e);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    bus.x_raw = 1'b1;
    bus.y_raw = 1'b1;

    // Reset held with both raw inputs high, then release: joint 0->1 at E6.
    add(3, 1, 1, 1, 5'b00000, "reset");
    add(6, 0, 1, 1, 5'b00000, "rst_release_wait");
    add(1, 0, 1, 1, 5'b11111, "rst_release_commit");
    add(2, 0, 1, 1, 5'b11000, "hold11");
    // Both fall together: upd only.
    add(6, 0, 0, 0, 5'b11000, "drop_both_wait");
    add(1, 0, 0, 0, 5'b00001, "drop_both_commit");
    add(2, 0, 0, 0, 5'b00000, "idle");
    // Single x rise, then x fall.
    add(6, 0, 1, 0, 5'b00000, "x_rise_wait");
    add(1, 0, 1, 0, 5'b10101, "x_rise_commit");
    add(3, 0, 1, 0, 5'b10000, "x_hold");
    add(6, 0, 0, 0, 5'b10000, "x_fall_wait");
    add(1, 0, 0, 0, 5'b00001, "x_fall_commit");
    add(2, 0, 0, 0, 5'b00000, "idle");
    // Glitches of 3 and 4 raw cycles are rejected.
    add(3, 0, 1, 0, 5'b00000, "glitch3");
    add(10, 0, 0, 0, 5'b00000, "glitch3_after");
    add(4, 0, 1, 0, 5'b00000, "glitch4");
    add(10, 0, 0, 0, 5'b00000, "glitch4_after");
    // A 5-cycle raw pulse is the shortest that commits; its fall follows.
    add(5, 0, 1, 0, 5'b00000, "pulse5");
    add(1, 0, 0, 0, 5'b00000, "pulse5_wait");
    add(1, 0, 0, 0, 5'b10101, "pulse5_commit");
    add(4, 0, 0, 0, 5'b10000, "pulse5_hold");
    add(1, 0, 0, 0, 5'b00001, "pulse5_fall");
    add(2, 0, 0, 0, 5'b00000, "idle");
    // Staggered arrival: x at E0, y at E2, joint commit at E8 not E6.
    add(2, 0, 1, 0, 5'b00000, "stagger_x");
    add(6, 0, 1, 1, 5'b00000, "stagger_xy");
    add(1, 0, 1, 1, 5'b11111, "stagger_commit");
    add(2, 0, 1, 1, 5'b11000, "stagger_hold");
    // Go to x=0,y=1, then y falls: upd without y_rise.
    add(6, 0, 0, 1, 5'b11000, "x_drop_wait");
    add(1, 0, 0, 1, 5'b01001, "x_drop_commit");
    add(2, 0, 0, 1, 5'b01000, "hold01");
    add(6, 0, 0, 0, 5'b01000, "y_fall_wait");
    add(1, 0, 0, 0, 5'b00001, "y_fall_commit");
    add(2, 0, 0, 0, 5'b00000, "idle");
    // Reset at E3 while x is debouncing, x dropped before E4.
    add(3, 0, 1, 0, 5'b00000, "rstmid");
    add(1, 1, 1, 0, 5'b00000, "rstmid_rst");
    add(10, 0, 0, 0, 5'b00000, "rstmid_after");

    foreach (tbl[i]) step(tbl[i].r, tbl[i].xr, tbl[i].yr, tbl[i].e, tbl[i].nm);

    // Reset mid-debounce on a pulse that would otherwise commit at E6.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 5'b00000, "rstmid5");
    step(1'b1, 1'b1, 1'b0, 5'b00000, "rstmid5_rst");
    step(1'b0, 1'b1, 1'b0, 5'b00000, "rstmid5");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 5'b00000, "rstmid5_after");

    // Chattering y blocks a settled x; x commits 6 edges after y settles.
    for (int i = 0; i < 12; i++) begin
      logic [3:0] iv;
      iv = 4'(i);
      step(1'b0, 1'b1, ~iv[1], 5'b00000, "chatter");
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 5'b00000, "chatter_settle");
    step(1'b0, 1'b1, 1'b0, 5'b10101, "chatter_commit");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 5'b10000, "chatter_fall_wait");
    step(1'b0, 1'b0, 1'b0, 5'b00001, "chatter_fall_commit");

    // Reset while committed levels are high clears them on the next edge.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 5'b00000, "pre_rst_wait");
    step(1'b0, 1'b1, 1'b1, 5'b11111, "pre_rst_commit");
    step(1'b1, 1'b1, 1'b1, 5'b00000, "rst_clears");
    step(1'b1, 1'b0, 1'b0, 5'b00000, "rst_clears");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
